apb_uart_host: RTL and testbench

APB_UART_HOST -- requirements
Module: apb_uart_host

---
 rtl/apb_uart_host.sv | 205 ++++++++++++++++++++
 tb/tb_apb_uart_host.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_host.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : apb_uart_host                                         |
// | Brief    : APB initiator that brings up a 16550-style UART and   |
// |            then shuttles TX/RX bytes between it and a stream     |
// |            interface, pacing TX with a FIFO credit counter.      |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module apb_uart_host #(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter int          UART_BASE      = 0,
  parameter logic [15:0] DIVISOR        = 16'h0036,
  parameter logic [7:0]  LCR_CFG        = 8'h03,
  parameter int          TX_FIFO_DEPTH  = 16
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [7:0]                tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic [7:0]                rx_data_o,
  output logic                      rx_perr_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output logic                      init_done_o,
  output logic                      err_o
);

  localparam int                      CREDIT_W  = $clog2(TX_FIFO_DEPTH) + 1;
  localparam logic [APB_ADDR_WIDTH-1:0] BASE_ADDR = APB_ADDR_WIDTH'(UART_BASE);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_GAP    = 3'd3,
    ST_DECIDE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_INIT = 2'd0,
    OP_LSR  = 2'd1,
    OP_RBR  = 2'd2,
    OP_THR  = 2'd3
  } op_t;

  state_t              state;
  op_t                 op;
  logic [2:0]          init_idx;
  logic [CREDIT_W-1:0] credit;
  logic                lsr_dr;
  logic                lsr_pe;
  logic                rx_pick;
  logic                tx_pick;
  logic                unused_prdata;

  assign unused_prdata = ^PRDATA[31:8];

  // Register index of each step of the bring-up sequence
  function automatic logic [2:0] init_reg(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'd3;
      3'd1:    return 3'd0;
      3'd2:    return 3'd1;
      3'd3:    return 3'd3;
      3'd4:    return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  // Data byte of each step: DLAB on, divisor, line format with DLAB off, FIFO reset, no IRQs
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h80;
      3'd1:    return DIVISOR[7:0];
      3'd2:    return DIVISOR[15:8];
      3'd3:    return LCR_CFG & 8'h7F;
      3'd4:    return 8'h06;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [APB_ADDR_WIDTH-1:0] reg_addr(input logic [2:0] r);
    return BASE_ADDR + APB_ADDR_WIDTH'(r);
  endfunction

  // RX drain outranks TX; tx_ready_o is the handshake of the DECIDE cycle that picks a THR write
  assign rx_pick    = lsr_dr && !rx_valid_o;
  assign tx_pick    = !rx_pick && (credit != '0) && tx_valid_i;
  assign tx_ready_o = (state == ST_DECIDE) && init_done_o && tx_pick;

  // Transfer sequencer: APB phases, init steps, poll/decide loop, credit and RX buffer
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= ST_IDLE;
      op          <= OP_INIT;
      init_idx    <= 3'd0;
      credit      <= '0;
      lsr_dr      <= 1'b0;
      lsr_pe      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rx_data_o   <= 8'h00;
      rx_perr_o   <= 1'b0;
      rx_valid_o  <= 1'b0;
      init_done_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          op       <= OP_INIT;
          init_idx <= 3'd0;
          PADDR    <= reg_addr(init_reg(3'd0));
          PWDATA   <= {24'h0, init_byte(3'd0)};
          PWRITE   <= 1'b1;
          PSEL     <= 1'b1;
          state    <= ST_SETUP;
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= ST_GAP;
            if (PSLVERR) begin
              err_o <= 1'b1;
            end
            if (op == OP_LSR) begin
              lsr_dr <= PRDATA[0];
              lsr_pe <= PRDATA[2];
              if (PRDATA[5]) begin
                credit <= CREDIT_W'(TX_FIFO_DEPTH);
              end
            end else if (op == OP_RBR) begin
              rx_data_o  <= PRDATA[7:0];
              rx_perr_o  <= lsr_pe;
              rx_valid_o <= 1'b1;
              lsr_dr     <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (op == OP_INIT && init_idx != 3'd5) begin
            init_idx <= init_idx + 3'd1;
            PADDR    <= reg_addr(init_reg(init_idx + 3'd1));
            PWDATA   <= {24'h0, init_byte(init_idx + 3'd1)};
            PWRITE   <= 1'b1;
            PSEL     <= 1'b1;
            state    <= ST_SETUP;
          end else begin
            if (op == OP_INIT) begin
              init_done_o <= 1'b1;
            end
            state <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          PSEL  <= 1'b1;
          state <= ST_SETUP;
          if (rx_pick) begin
            op     <= OP_RBR;
            PADDR  <= reg_addr(3'd0);
            PWDATA <= '0;
            PWRITE <= 1'b0;
          end else if (tx_pick) begin
            op     <= OP_THR;
            PADDR  <= reg_addr(3'd0);
            PWDATA <= {24'h0, tx_data_i};
            PWRITE <= 1'b1;
            credit <= credit - CREDIT_W'(1);
          end else begin
            op     <= OP_LSR;
            PADDR  <= reg_addr(3'd5);
            PWDATA <= '0;
            PWRITE <= 1'b0;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_host.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_apb_uart_host                                      |
// | Brief    : Directed self-checking bench for apb_uart_host with a |
// |            simple APB UART target model.                         |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_apb_uart_host;

  localparam int AW = 12;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic [7:0]    tx_data_i = 8'h00;
  logic          tx_valid_i = 1'b0;
  logic          tx_ready_o;
  logic [7:0]    rx_data_o;
  logic          rx_perr_o, rx_valid_o;
  logic          rx_ready_i = 1'b0;
  logic          init_done_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Target model knobs
  logic [7:0] lsr_val   = 8'h00;
  logic [7:0] rbr_val   = 8'h00;
  int         ready_wait = 0;
  logic       slverr_en = 1'b0;
  int         acc_cnt   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [7:0]    data;
  } xfer_t;
  xfer_t log_q[$];
  xfer_t mon_x;

  int init_addr[6] = '{3, 0, 1, 3, 2, 1};
  logic [7:0] init_data[6] = '{8'h80, 8'h36, 8'h00, 8'h03, 8'h06, 8'h00};

  apb_uart_host dut (
    .CLK(CLK), .RSTN(RSTN),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .init_done_o(init_done_o), .err_o(err_o)
  );

  always #5 CLK = ~CLK;

  assign PRDATA  = (PADDR[2:0] == 3'd5) ? {24'h0, lsr_val} : {24'h0, rbr_val};
  assign PREADY  = (acc_cnt >= ready_wait);
  assign PSLVERR = slverr_en;

  // Wait-state counter and completed-transfer log
  always @(posedge CLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (RSTN && PSEL && PENABLE && PREADY) begin
      mon_x.addr = PADDR;
      mon_x.wr   = PWRITE;
      mon_x.data = PWDATA[7:0];
      log_q.push_back(mon_x);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int rbr_reads();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].addr == 0 && !log_q[i].wr) n++;
    return n;
  endfunction

  task automatic test_reset();
    RSTN = 1'b0;
    tx_valid_i = 1'b1;
    tx_data_i = 8'hEE;
    repeat (3) tick();
    n_tests++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000", {PSEL, PENABLE, PWRITE}); end
    n_tests++;
    if (PADDR !== '0) begin n_fail++; $display("FAIL reset_paddr: got %h want 0", PADDR); end
    n_tests++;
    if (PWDATA !== 32'h0) begin n_fail++; $display("FAIL reset_pwdata: got %h want 0", PWDATA); end
    n_tests++;
    if ({tx_ready_o, rx_valid_o, rx_perr_o, init_done_o, err_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {tx_ready_o, rx_valid_o, rx_perr_o, init_done_o, err_o});
    end
    n_tests++;
    if (rx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_rxdata: got %h want 00", rx_data_o); end
  endtask

  task automatic test_init();
    int k, ph;
    @(negedge CLK);
    RSTN = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (c <= 18) begin
        k  = (c - 1) / 3;
        ph = (c - 1) % 3;
        n_tests++;
        if ({PSEL, PENABLE} !== ((ph == 0) ? 2'b10 : (ph == 1) ? 2'b11 : 2'b00)) begin
          n_fail++; $display("FAIL init_phase c=%0d: got %b ph=%0d", c, {PSEL, PENABLE}, ph);
        end
        if (ph != 2) begin
          n_tests++;
          if ({PWRITE, PADDR, PWDATA} !== {1'b1, AW'(init_addr[k]), 24'h0, init_data[k]}) begin
            n_fail++; $display("FAIL init_write%0d: got w=%b a=%h d=%h want a=%0d d=%h", k, PWRITE, PADDR, PWDATA, init_addr[k], init_data[k]);
          end
        end
      end
      n_tests++;
      if (init_done_o !== (c == 19)) begin n_fail++; $display("FAIL init_done c=%0d: got %b want %b", c, init_done_o, c == 19); end
      n_tests++;
      if (tx_ready_o !== 1'b0) begin n_fail++; $display("FAIL init_txready c=%0d: got %b want 0", c, tx_ready_o); end
    end
    tx_valid_i = 1'b0;
  endtask

  task automatic test_tx_burst();
    int start, accepted, w, data_bad, total_wr, gap_pre, gap_mid, gap_post;
    int gap[21];
    start = log_q.size();
    accepted = 0;
    lsr_val = 8'h60;
    tx_data_i = 8'h10;
    tx_valid_i = 1'b1;
    for (int cyc = 0; cyc < 2000 && accepted < 20; cyc++) begin
      @(negedge CLK);
      if (tx_ready_o) begin
        accepted++;
        tick();
        tx_data_i = 8'(16 + accepted);
        if (accepted == 20) tx_valid_i = 1'b0;
      end
    end
    repeat (40) tick();
    lsr_val = 8'h00;
    n_tests++;
    if (accepted !== 20) begin n_fail++; $display("FAIL tx_ready_pulses: got %0d want 20", accepted); end
    foreach (gap[i]) gap[i] = 0;
    w = 0; data_bad = 0; total_wr = 0;
    for (int i = start; i < log_q.size(); i++) begin
      if (log_q[i].wr) begin
        total_wr++;
        if (w < 20) begin
          if (log_q[i].addr !== 0 || log_q[i].data !== 8'(16 + w)) data_bad++;
          w++;
        end
      end else if (w > 0 && w < 20) begin
        gap[w]++;
      end
    end
    gap_pre = 0; gap_post = 0;
    for (int i = 1; i < 16; i++) gap_pre += gap[i];
    for (int i = 17; i < 20; i++) gap_post += gap[i];
    gap_mid = gap[16];
    n_tests++;
    if (total_wr !== 20) begin n_fail++; $display("FAIL tx_thr_count: got %0d want 20", total_wr); end
    n_tests++;
    if (data_bad !== 0) begin n_fail++; $display("FAIL tx_thr_data: got %0d bad writes want 0", data_bad); end
    n_tests++;
    if (gap_pre !== 0) begin n_fail++; $display("FAIL tx_first16_polls: got %0d reads want 0", gap_pre); end
    n_tests++;
    if (gap_mid !== 1) begin n_fail++; $display("FAIL tx_repoll: got %0d reads want 1", gap_mid); end
    n_tests++;
    if (gap_post !== 0) begin n_fail++; $display("FAIL tx_last4_polls: got %0d reads want 0", gap_post); end
  endtask

  task automatic test_rx_hold();
    int bad, rd0;
    lsr_val = 8'h61;
    rbr_val = 8'h5A;
    rx_ready_i = 1'b0;
    for (int cyc = 0; cyc < 200 && !rx_valid_o; cyc++) tick();
    n_tests++;
    if (rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL rx_valid_timeout: got %b want 1", rx_valid_o); end
    n_tests++;
    if ({rx_perr_o, rx_data_o} !== {1'b0, 8'h5A}) begin n_fail++; $display("FAIL rx_data: got perr=%b d=%h want 0/5a", rx_perr_o, rx_data_o); end
    rd0 = rbr_reads();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h5A) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL rx_hold: got %0d bad cycles want 0", bad); end
    n_tests++;
    if (rbr_reads() !== rd0) begin n_fail++; $display("FAIL rx_no_reread: got %0d reads want %0d", rbr_reads(), rd0); end
    @(negedge CLK);
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    n_tests++;
    if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL rx_consume: got %b want 0", rx_valid_o); end
    for (int cyc = 0; cyc < 200 && !rx_valid_o; cyc++) tick();
    n_tests++;
    if (rbr_reads() !== rd0 + 1) begin n_fail++; $display("FAIL rx_reread: got %0d reads want %0d", rbr_reads(), rd0 + 1); end
    lsr_val = 8'h00;
    repeat (20) tick();
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    repeat (20) tick();
    n_tests++;
    if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL rx_idle: got %b want 0", rx_valid_o); end
  endtask

  task automatic test_rx_parity();
    lsr_val = 8'h65;
    rbr_val = 8'hA5;
    for (int cyc = 0; cyc < 200 && !rx_valid_o; cyc++) tick();
    n_tests++;
    if ({rx_valid_o, rx_perr_o, rx_data_o} !== {2'b11, 8'hA5}) begin
      n_fail++; $display("FAIL rx_parity: got v=%b perr=%b d=%h want 1/1/a5", rx_valid_o, rx_perr_o, rx_data_o);
    end
    lsr_val = 8'h00;
    repeat (20) tick();
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
  endtask

  task automatic test_wait_err();
    logic [AW-1:0] a0;
    logic [31:0]   d0;
    int bad, found, n0;
    ready_wait = 5;
    tx_data_i = 8'h3C;
    tx_valid_i = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 300 && found == 0; cyc++) begin
      tick();
      if (PSEL && !PENABLE && PWRITE) found = 1;
    end
    tx_valid_i = 1'b0;
    slverr_en = 1'b1;
    n_tests++;
    if (found !== 1) begin n_fail++; $display("FAIL wait_thr_setup: got %0d want 1", found); end
    a0 = PADDR;
    d0 = PWDATA;
    n_tests++;
    if ({a0, d0} !== {AW'(0), 32'h3C}) begin n_fail++; $display("FAIL wait_thr_fields: got a=%h d=%h want 0/3c", a0, d0); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!PSEL || !PENABLE || PREADY || !PWRITE || PADDR !== a0 || PWDATA !== d0 || err_o) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL wait_stable: got %0d bad cycles want 0", bad); end
    tick();
    n_tests++;
    if ({PSEL, PENABLE, PREADY, err_o} !== 4'b1110) begin n_fail++; $display("FAIL wait_complete: got %b want 1110", {PSEL, PENABLE, PREADY, err_o}); end
    tick();
    slverr_en = 1'b0;
    ready_wait = 0;
    n_tests++;
    if ({PSEL, err_o} !== 2'b01) begin n_fail++; $display("FAIL err_set: got psel/err=%b want 01", {PSEL, err_o}); end
    n0 = log_q.size();
    repeat (30) tick();
    n_tests++;
    if (log_q.size() < n0 + 3 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL err_continue: got %0d new xfers err=%b want >=3 and 1", log_q.size() - n0, err_o);
    end
  endtask

  task automatic test_reset_mid();
    int found, st, bad;
    ready_wait = 3;
    @(negedge CLK);
    RSTN = 1'b0;
    tick();
    @(negedge CLK);
    RSTN = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 200 && found == 0; cyc++) begin
      tick();
      if (PSEL && PENABLE && PWRITE && PADDR == AW'(1) && !init_done_o) found = 1;
    end
    n_tests++;
    if (found !== 1) begin n_fail++; $display("FAIL rstmid_dlm_access: got %0d want 1", found); end
    #2;
    RSTN = 1'b0;
    #1;
    n_tests++;
    if ({PSEL, PENABLE, init_done_o, err_o} !== 4'b0000 || PADDR !== '0) begin
      n_fail++; $display("FAIL rstmid_async: got ctrl=%b a=%h want 0000/0", {PSEL, PENABLE, init_done_o, err_o}, PADDR);
    end
    ready_wait = 0;
    @(negedge CLK);
    RSTN = 1'b1;
    st = log_q.size();
    repeat (25) tick();
    n_tests++;
    if (log_q.size() < st + 6 || log_q[st].addr !== AW'(3) || log_q[st].data !== 8'h80 || !log_q[st].wr) begin
      n_fail++; $display("FAIL rstmid_restart: got %0d xfers first a=%h d=%h want LCR 80", log_q.size() - st,
                         (log_q.size() > st) ? log_q[st].addr : AW'(0), (log_q.size() > st) ? log_q[st].data : 8'h00);
    end else begin
      bad = 0;
      for (int i = 0; i < 6; i++)
        if (log_q[st + i].addr !== AW'(init_addr[i]) || log_q[st + i].data !== init_data[i] || !log_q[st + i].wr) bad++;
      n_tests++;
      if (bad !== 0) begin n_fail++; $display("FAIL rstmid_sequence: got %0d bad writes want 0", bad); end
    end
    n_tests++;
    if (init_done_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_done: got %b want 1", init_done_o); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_tx_burst();
    test_rx_hold();
    test_rx_parity();
    test_wait_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
